egg_timer_countdown: RTL and testbench

- Sequential countdown core of the egg timer. It holds the remaining time as a binary seconds count and decrements it once per second while running.
- It drives the binary-to-BCD converter directly; out_seconds is that converter's 16-bit binary input.
- Button inputs arrive as clean single-cycle pulses from the debounce/edge-detect stage.
- It flags expiry and produces a square-wave alarm for the buzzer.

---
 rtl/egg_timer_countdown.sv | 140 ++++++++++++++
 tb/tb_egg_timer_countdown.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/egg_timer_countdown.sv
// Purpose: egg-timer countdown core; holds remaining seconds, decrements once per second, raises expiry and a buzzer square wave.
// Latency: every button pulse takes effect on the next clock edge; all outputs come straight from registers.
// Backpressure: none; a pulse is accepted on any cycle, and a lower-priority pulse in the same cycle is dropped (except add on a tick).
module egg_timer_countdown #(
    parameter int unsigned TICKS_PER_SECOND  = 100000000,
    parameter int unsigned ADD_STEP          = 30,
    parameter int unsigned MAX_SECONDS       = 9999,
    parameter int unsigned ALARM_HALF_PERIOD = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop_pulse,
    input  logic        add_pulse,
    input  logic        clear_pulse,
    output logic [15:0] out_seconds,
    output logic        running,
    output logic        expired,
    output logic        alarm
);

    localparam int PW = (TICKS_PER_SECOND > 2) ? $clog2(TICKS_PER_SECOND) : 1;
    localparam int AW = (ALARM_HALF_PERIOD > 1) ? $clog2(ALARM_HALF_PERIOD) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SECOND - 1);
    localparam logic [AW-1:0] ALM_LAST   = AW'(ALARM_HALF_PERIOD - 1);
    localparam logic [16:0]   ADD_STEP_W = 17'(ADD_STEP);
    localparam logic [16:0]   MAX_W      = 17'(MAX_SECONDS);
    localparam logic [15:0]   MAX_SEC16  = 16'(MAX_SECONDS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUNNING = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [15:0]   sec_q, sec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] alm_cnt_q, alm_cnt_d;
    logic          alarm_q, alarm_d;

    logic          tick;
    logic [16:0]   add_sum;
    logic [15:0]   add_sat;

    // One-second tick and the saturating add; the add folds in the tick's decrement
    // so an add landing on a tick yields min(sec - 1 + step, max).
    always_comb begin
        tick    = (state_q == S_RUNNING) && (presc_q == PRESC_LAST);
        add_sum = {1'b0, sec_q} + ADD_STEP_W - {16'd0, tick};
        add_sat = (add_sum > MAX_W) ? MAX_SEC16 : add_sum[15:0];
    end

    // Next-state: clear beats start/stop beats add; prescaler advances only while running.
    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        presc_d   = presc_q;
        alm_cnt_d = alm_cnt_q;
        alarm_d   = alarm_q;

        if (clear_pulse) begin
            state_d   = S_IDLE;
            sec_d     = 16'd0;
            presc_d   = '0;
            alm_cnt_d = '0;
            alarm_d   = 1'b0;
        end else if (start_stop_pulse) begin
            case (state_q)
                S_IDLE: begin
                    if (sec_q != 16'd0) begin
                        state_d = S_RUNNING;
                        presc_d = '0;
                    end
                end
                // Pause holds the prescaler, even at its last count, so a pause
                // on the tick cycle defers that decrement to the first resumed cycle.
                S_RUNNING: state_d = S_PAUSED;
                S_PAUSED:  state_d = S_RUNNING;
                default: begin
                    state_d   = S_IDLE;
                    alarm_d   = 1'b0;
                    alm_cnt_d = '0;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE, S_PAUSED: begin
                    if (add_pulse) begin
                        sec_d = add_sat;
                    end
                end
                S_RUNNING: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (add_pulse) begin
                        // Covers the tick case too, including rescue from the last second.
                        sec_d = add_sat;
                    end else if (tick) begin
                        sec_d = sec_q - 16'd1;
                        if (sec_q == 16'd1) begin
                            state_d   = S_EXPIRED;
                            alm_cnt_d = '0;
                            alarm_d   = 1'b1;
                        end
                    end
                end
                default: begin
                    if (alm_cnt_q == ALM_LAST) begin
                        alm_cnt_d = '0;
                        alarm_d   = ~alarm_q;
                    end else begin
                        alm_cnt_d = alm_cnt_q + AW'(1);
                    end
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset to idle/zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sec_q     <= 16'd0;
            presc_q   <= '0;
            alm_cnt_q <= '0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            alm_cnt_q <= alm_cnt_d;
            alarm_q   <= alarm_d;
        end
    end

    assign out_seconds = sec_q;
    assign running     = (state_q == S_RUNNING);
    assign expired     = (state_q == S_EXPIRED);
    assign alarm       = alarm_q;

endmodule

// File: tb/tb_egg_timer_countdown.sv
// Purpose: directed self-checking bench for egg_timer_countdown with short tick and alarm periods.
// Latency: inputs change on the falling edge, outputs are sampled on the next falling edge.
// Backpressure: not applicable; pulses are driven one cycle wide.
module tb_egg_timer_countdown;

    logic        clk;
    logic        rst;
    logic        start_stop_pulse;
    logic        add_pulse;
    logic        clear_pulse;
    logic [15:0] out_seconds;
    logic        running;
    logic        expired;
    logic        alarm;

    int checks   = 0;
    int failures = 0;

    egg_timer_countdown #(
        .TICKS_PER_SECOND (4),
        .ADD_STEP         (30),
        .MAX_SECONDS      (9999),
        .ALARM_HALF_PERIOD(2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_stop_pulse(start_stop_pulse),
        .add_pulse       (add_pulse),
        .clear_pulse     (clear_pulse),
        .out_seconds     (out_seconds),
        .running         (running),
        .expired         (expired),
        .alarm           (alarm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ss;
        start_stop_pulse = 1'b1;
        @(negedge clk);
        start_stop_pulse = 1'b0;
    endtask

    task automatic pulse_add;
        add_pulse = 1'b1;
        @(negedge clk);
        add_pulse = 1'b0;
    endtask

    task automatic pulse_clr;
        clear_pulse = 1'b1;
        @(negedge clk);
        clear_pulse = 1'b0;
    endtask

    initial begin
        int exp_alarm[6];
        exp_alarm = '{1, 0, 0, 1, 1, 0};

        rst = 1'b0;
        start_stop_pulse = 1'b0;
        add_pulse = 1'b0;
        clear_pulse = 1'b0;

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #3;
        chk_eq("rst_seconds", out_seconds, 0);
        chk_eq("rst_running", running, 0);
        chk_eq("rst_expired", expired, 0);
        chk_eq("rst_alarm", alarm, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(1);

        // Start with zero seconds is ignored.
        pulse_ss();
        chk_eq("idle0_start_running", running, 0);
        chk_eq("idle0_start_seconds", out_seconds, 0);

        // Saturation at 9999.
        repeat (333) pulse_add();
        chk_eq("add_333", out_seconds, 9990);
        pulse_add();
        chk_eq("add_334_sat", out_seconds, 9999);
        pulse_add();
        chk_eq("add_335_sat", out_seconds, 9999);
        pulse_clr();
        chk_eq("clear_seconds", out_seconds, 0);

        // Countdown to expiry.
        pulse_add();
        chk_eq("add_30", out_seconds, 30);
        pulse_ss();
        chk_eq("start_running", running, 1);
        wait_cyc(3);
        chk_eq("pre_first_tick", out_seconds, 30);
        wait_cyc(1);
        chk_eq("first_tick", out_seconds, 29);
        wait_cyc(115);
        chk_eq("one_left_seconds", out_seconds, 1);
        chk_eq("one_left_expired", expired, 0);
        wait_cyc(1);
        chk_eq("expiry_seconds", out_seconds, 0);
        chk_eq("expiry_expired", expired, 1);
        chk_eq("expiry_running", running, 0);
        chk_eq("expiry_alarm0", alarm, 1);
        for (int i = 0; i < 6; i++) begin
            wait_cyc(1);
            chk_eq($sformatf("alarm_pat%0d", i + 1), alarm, exp_alarm[i]);
        end
        pulse_ss();
        chk_eq("ack_expired", expired, 0);
        chk_eq("ack_alarm", alarm, 0);
        chk_eq("ack_running", running, 0);
        chk_eq("ack_seconds", out_seconds, 0);

        // Pause / resume keeps the prescaler phase.
        pulse_add();
        pulse_ss();
        wait_cyc(2);
        pulse_ss();
        chk_eq("pause_running", running, 0);
        chk_eq("pause_seconds", out_seconds, 30);
        wait_cyc(50);
        chk_eq("pause_hold_seconds", out_seconds, 30);
        chk_eq("pause_hold_running", running, 0);
        pulse_ss();
        chk_eq("resume_running", running, 1);
        wait_cyc(1);
        chk_eq("resume_plus1", out_seconds, 30);
        wait_cyc(1);
        chk_eq("resume_plus2", out_seconds, 29);

        // Pause on the tick cycle: no decrement, tick fires on first resumed cycle.
        wait_cyc(3);
        chk_eq("pre_tick_pause", out_seconds, 29);
        pulse_ss();
        chk_eq("tick_pause_seconds", out_seconds, 29);
        chk_eq("tick_pause_running", running, 0);
        pulse_ss();
        chk_eq("tick_resume_seconds", out_seconds, 29);
        wait_cyc(1);
        chk_eq("tick_resume_dec", out_seconds, 28);

        // Add on the final tick cancels expiry.
        pulse_clr();
        pulse_add();
        pulse_ss();
        wait_cyc(116);
        chk_eq("rescue_one_left", out_seconds, 1);
        wait_cyc(3);
        pulse_add();
        chk_eq("rescue_seconds", out_seconds, 30);
        chk_eq("rescue_running", running, 1);
        chk_eq("rescue_expired", expired, 0);
        wait_cyc(4);
        chk_eq("rescue_next_tick", out_seconds, 29);

        // Clear beats start/stop and add.
        pulse_clr();
        pulse_add();
        pulse_add();
        pulse_ss();
        wait_cyc(60);
        chk_eq("prio_at45", out_seconds, 45);
        clear_pulse = 1'b1;
        start_stop_pulse = 1'b1;
        add_pulse = 1'b1;
        @(negedge clk);
        clear_pulse = 1'b0;
        start_stop_pulse = 1'b0;
        add_pulse = 1'b0;
        chk_eq("prio_seconds", out_seconds, 0);
        chk_eq("prio_running", running, 0);
        chk_eq("prio_expired", expired, 0);

        // Reset while the alarm sounds.
        pulse_add();
        pulse_ss();
        wait_cyc(120);
        chk_eq("pre_rst_expired", expired, 1);
        chk_eq("pre_rst_alarm", alarm, 1);
        #2 rst = 1'b1;
        #1;
        chk_eq("rst_exp_alarm", alarm, 0);
        chk_eq("rst_exp_expired", expired, 0);
        chk_eq("rst_exp_seconds", out_seconds, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(2);
        chk_eq("post_rst_alarm", alarm, 0);
        chk_eq("post_rst_running", running, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
